// File: rtl/nn_pkg.sv
// nn_pkg: constants and types shared by the output-layer bias sequencer, the bias ROM
// and the MAC array.
//   NUM_OUT    neurons per inference (bias ROM depth)
//   ADDR_W     bias ROM address width
//   ACC_W      signed accumulator width from the MAC array
//   BIAS_W     signed bias word width
//   OUT_W      signed saturated logit width
//   BIAS_SHIFT left shift taking the bias Q-format to the accumulator Q-format
package nn_pkg;

    localparam int unsigned NUM_OUT    = 10;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned BIAS_W     = 16;
    localparam int unsigned OUT_W      = 16;
    localparam int unsigned BIAS_SHIFT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } seq_state_e;

endpackage

// File: rtl/bias_add_seq_if.sv
// bias_add_seq_if: stream and ROM signals of the bias sequencer.
//   acc_valid/acc_ready/acc_data         MAC sum stream into the sequencer
//   bias_addr/bias_data                  combinational-read bias ROM port
//   out_valid/out_ready/out_data/
//   out_idx/out_last                     logit stream out of the sequencer
// Modports: master = sequencer side, slave = environment side (MAC, ROM, consumer).
interface bias_add_seq_if;
    import nn_pkg::*;

    logic                     acc_valid;
    logic                     acc_ready;
    logic signed [ACC_W-1:0]  acc_data;
    logic [ADDR_W-1:0]        bias_addr;
    logic signed [BIAS_W-1:0] bias_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [ADDR_W-1:0]        out_idx;
    logic                     out_last;

    modport master (
        input  acc_valid, acc_data, bias_data, out_ready,
        output acc_ready, bias_addr, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        output acc_valid, acc_data, bias_data, out_ready,
        input  acc_ready, bias_addr, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/bias_sat_add.sv
// bias_sat_add: combinational bias add with saturation.
//   acc  in  AccW   signed accumulator value
//   bias in  BiasW  signed bias word
//   sat  out OutW   sat(sext(acc) + (sext(bias) <<< BiasShift)), sum formed in AccW+1 bits
module bias_sat_add import nn_pkg::*; #(
    parameter int unsigned AccW      = ACC_W,
    parameter int unsigned BiasW     = BIAS_W,
    parameter int unsigned OutW      = OUT_W,
    parameter int unsigned BiasShift = BIAS_SHIFT
) (
    input  logic signed [AccW-1:0]  acc,
    input  logic signed [BiasW-1:0] bias,
    output logic signed [OutW-1:0]  sat
);

    localparam int unsigned SumW = AccW + 1;

    logic signed [SumW-1:0] acc_ext;
    logic signed [SumW-1:0] bias_ext;
    logic signed [SumW-1:0] sum;

    always_comb begin
        acc_ext  = SumW'(acc);
        bias_ext = SumW'(bias) <<< BiasShift;
        sum      = acc_ext + bias_ext;
        // In range iff every bit from the output sign bit upward agrees.
        if ((&sum[SumW-1:OutW-1]) || !(|sum[SumW-1:OutW-1])) begin
            sat = sum[OutW-1:0];
        end else if (sum[SumW-1]) begin
            sat = {1'b1, {(OutW-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OutW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/bias_add_seq.sv
// bias_add_seq: output-layer bias sequencer. On start it walks the NUM_OUT neurons, drives the
// bias ROM address, adds the aligned bias to each streamed MAC sum, saturates, and emits one
// logit per neuron.
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset (aborts a pass, no done)
//   start     1-cycle pulse, honoured only in idle
//   bus       bias_add_seq_if.master: acc stream in, bias ROM port, logit stream out
//   busy      high from accepted start until the pass returns to idle
//   done      1-cycle pulse when the last logit has been taken
//   class_idx argmax of the pass logits (lower index wins ties) when BIAS_ARGMAX_EN is
//             defined; tied to 0 otherwise
module bias_add_seq import nn_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    bias_add_seq_if.master     bus,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  class_idx
);

    seq_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]       out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;

    logic                    acc_ready;
    logic                    accept;
    logic                    pop;
    logic                    is_last;
    logic signed [OUT_W-1:0] sat;

    bias_sat_add #(
        .AccW      (ACC_W),
        .BiasW     (BIAS_W),
        .OutW      (OUT_W),
        .BiasShift (BIAS_SHIFT)
    ) u_sat (
        .acc  (bus.acc_data),
        .bias (bus.bias_data),
        .sat  (sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        // Single output register: a new sum may enter only if the held logit leaves this cycle.
        acc_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
        accept    = bus.acc_valid && acc_ready;
        pop       = out_valid_q && bus.out_ready;
        is_last   = (idx_q == ADDR_W'(NUM_OUT - 1));

        if (pop) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sat;
            out_idx_d   = idx_q;
            out_last_d  = is_last;
            // Hold on the last neuron so the counter never wraps within a pass.
            if (!is_last) begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                if (accept && is_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Only the last logit can be pending here.
                if (pop) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.acc_ready = acc_ready;
    assign bus.bias_addr = idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

`ifdef BIAS_ARGMAX_EN
    logic signed [OUT_W-1:0] max_val_q, max_val_d;
    logic [ADDR_W-1:0]       max_idx_q, max_idx_d;
    logic [ADDR_W-1:0]       class_idx_q, class_idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val_q   <= '0;
            max_idx_q   <= '0;
            class_idx_q <= '0;
        end else begin
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            class_idx_q <= class_idx_d;
        end
    end

    always_comb begin
        max_val_d   = max_val_q;
        max_idx_d   = max_idx_q;
        class_idx_d = class_idx_q;
        // First neuron seeds the max; strict compare keeps the lower index on ties.
        if (accept && ((idx_q == '0) || (sat > max_val_q))) begin
            max_val_d = sat;
            max_idx_d = idx_q;
        end
        if (state_q == StDone) begin
            class_idx_d = max_idx_q;
        end
    end

    assign class_idx = class_idx_q;
`else
    assign class_idx = '0;
`endif

endmodule

// File: tb/tb_bias_add_seq.sv
// tb_bias_add_seq: randomized bench for bias_add_seq with a scoreboard. The driver pushes the
// expected logit for every accepted MAC sum; a negedge monitor pops and compares each logit
// the DUT hands over, and checks the done pulse timing.
module tb_bias_add_seq;
    import nn_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] class_idx;

    bias_add_seq_if bus ();

    bias_add_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx)
    );

    always #5 clk = ~clk;

    logic signed [BIAS_W-1:0] rom [2**ADDR_W];
    assign bus.bias_data = rom[bus.bias_addr];

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   done_pending = 0;
    bit   mon_due;
    int   pass_acc[NUM_OUT];
    int   pass_logit[NUM_OUT];
    int   stall_left = 0;
    bit   rand_ready = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic abort_timeout(input string name);
        errors++;
        checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench stopped on timeout");
    endtask

    // Reference: the logit is the mathematical sum clamped to the signed OUT_W range.
    function automatic int model_logit(input int acc, input int bias);
        longint s, hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        s  = longint'(acc) + longint'(bias) * (longint'(1) << BIAS_SHIFT);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return int'(s);
    endfunction

    function automatic int model_argmax();
        int best = 0;
        for (int i = 1; i < NUM_OUT; i++) begin
            if (pass_logit[i] > pass_logit[best]) best = i;
        end
        return best;
    endfunction

    task automatic drive_ready();
        if (stall_left > 0) bus.out_ready = 1'b0;
        else if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        else bus.out_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every logit that leaves the DUT with the scoreboard head.
    always @(negedge clk) begin
        mon_due = done_pending;
        done_pending = 0;
        if (rst_n && (done || mon_due)) check("done_pulse", longint'(done), longint'(mon_due));
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_logit: got idx %0d data %0d, expected none",
                         bus.out_idx, bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", longint'(bus.out_data), longint'(mon_e.data));
                check("out_idx", longint'(bus.out_idx), longint'(mon_e.idx));
                check("out_last", longint'(bus.out_last), longint'(mon_e.last));
                if (mon_e.last) done_pending = 1;
            end
        end
    end

    // Runs one pass from pass_acc[]. stall_at/start_at/abort_at name a beat, or -1 for none.
    task automatic run_pass(input int stall_at, input int start_at, input int abort_at);
        bit accepted;
        bit stalled = 0;
        int cnt;

        start = 1'b1;
        bus.acc_valid = 1'b0;
        drive_ready();
        @(negedge clk);
        next_cycle();
        start = 1'b0;

        for (int k = 0; k < NUM_OUT; k++) begin
            if (k == abort_at) begin
                bus.acc_valid = 1'b0;
                bus.out_ready = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                next_cycle();
                rst_n = 1'b1;
                exp_q.delete();
                done_pending = 0;
                @(negedge clk);
                check("abort_busy", longint'(busy), 0);
                check("abort_out_valid", longint'(bus.out_valid), 0);
                check("abort_bias_addr", longint'(bus.bias_addr), 0);
                next_cycle();
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.acc_valid = 1'b0;
                drive_ready();
                @(negedge clk);
                next_cycle();
            end
            bus.acc_valid = 1'b1;
            bus.acc_data  = pass_acc[k];
            accepted = 0;
            cnt = 0;
            while (!accepted) begin
                start = (k == start_at && cnt == 0);
                if (k == stall_at && !stalled) begin
                    stall_left = 5;
                    stalled = 1;
                end
                drive_ready();
                @(negedge clk);
                if (stall_left > 0) begin
                    if (bus.out_valid) begin
                        check("stall_acc_ready", longint'(bus.acc_ready), 0);
                        if (exp_q.size() > 0)
                            check("stall_out_data", longint'(bus.out_data),
                                  longint'(exp_q[0].data));
                    end
                    stall_left--;
                end
                if (start) check("busy_start_in_run", longint'(busy), 1);
                if (bus.acc_valid && bus.acc_ready) begin
                    check("bias_addr", longint'(bus.bias_addr), longint'(k));
                    pass_logit[k] = model_logit(pass_acc[k], int'(rom[k]));
                    exp_q.push_back('{data: pass_logit[k], idx: k, last: (k == NUM_OUT - 1)});
                    accepted = 1;
                end
                next_cycle();
                cnt++;
                if (cnt > 100) abort_timeout("acc_accept");
            end
            start = 1'b0;
        end
        bus.acc_valid = 1'b0;

        cnt = 0;
        forever begin
            drive_ready();
            @(negedge clk);
            if (done) break;
            next_cycle();
            cnt++;
            if (cnt > 200) abort_timeout("done_wait");
        end
        next_cycle();
        @(negedge clk);
        check("busy_after_done", longint'(busy), 0);
`ifdef BIAS_ARGMAX_EN
        check("class_idx", longint'(class_idx), longint'(model_argmax()));
`else
        check("class_idx", longint'(class_idx), 0);
`endif
        next_cycle();
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = BIAS_W'(int'($urandom_range(0, 300)) - 150);
    endtask

    task automatic rand_accs();
        for (int i = 0; i < NUM_OUT; i++) begin
            if ($urandom_range(0, 3) == 0) pass_acc[i] = int'($urandom());
            else pass_acc[i] = int'($urandom_range(0, 70000)) - 35000;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = '0;

        // Reset for two cycles with start held high.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_acc_ready", longint'(bus.acc_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_idx", longint'(bus.out_idx), 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        check("rst_bias_addr", longint'(bus.bias_addr), 0);
        check("rst_class_idx", longint'(class_idx), 0);
        next_cycle();
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", longint'(busy), 0);
        next_cycle();

        // Ramp biases with a constant sum, full-rate drain.
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = BIAS_W'(i);
        for (int i = 0; i < NUM_OUT; i++) pass_acc[i] = 100 * 256;
        rand_ready = 0;
        run_pass(-1, -1, -1);

        // Saturation at both ends.
        rand_rom();
        rand_accs();
        rom[0] = 16'sh7FFF;
        rom[1] = 16'sh8000;
        pass_acc[0] = 32'h7FFF_0000;
        pass_acc[1] = 32'h8000_0000;
        run_pass(-1, -1, -1);
        check("sat_pos_model", longint'(pass_logit[0]), 32767);
        check("sat_neg_model", longint'(pass_logit[1]), -32768);

        // Backpressure window mid-pass.
        rand_rom();
        rand_accs();
        rand_ready = 1;
        run_pass(4, -1, -1);

        // Start ignored while running.
        rand_accs();
        run_pass(-1, 2, -1);

        // Reset at idx 4, then a clean pass restarting at neuron 0.
        rand_accs();
        run_pass(-1, -1, 4);
        rand_accs();
        run_pass(-1, -1, -1);

        // Tied maxima at neurons 3 and 7.
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = '0;
        for (int i = 0; i < NUM_OUT; i++) pass_acc[i] = int'($urandom_range(0, 49999)) - 30000;
        pass_acc[3] = 20000;
        pass_acc[7] = 20000;
        run_pass(-1, -1, -1);

        for (int r = 0; r < 4; r++) begin
            rand_rom();
            rand_accs();
            run_pass(int'($urandom_range(0, NUM_OUT - 1)), -1, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
